// File: rtl/sap_mem_arbiter.sv
// Round-robin two-port arbiter that shares the SAP single-port RAM between the CPU (port 0) and the loader (port 1).
// Optional grant/conflict statistics counters are enabled by defining ARB_STATS_EN.
module sap_mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          cpu_stall,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
`ifdef ARB_STATS_EN
  output logic [15:0]   gcnt0,
  output logic [15:0]   gcnt1,
  output logic [15:0]   conflict_cnt,
`endif
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

  logic       last;
  logic [7:0] burst_cnt;
  logic       rd_pend;
  logic       rd_id;
  logic       win;
  logic       grant;

  // The previous owner keeps the RAM only while it locks and is under the burst limit.
  always_comb begin
    win   = 1'b0;
    grant = 1'b0;
    if (!rst) begin
      if (req0 && req1) begin
        grant = 1'b1;
        if (!last) win = (lock0 && (burst_cnt < BURST_LIMIT)) ? 1'b0 : 1'b1;
        else       win = (lock1 && (burst_cnt < BURST_LIMIT)) ? 1'b1 : 1'b0;
      end else if (req0) begin
        grant = 1'b1;
        win   = 1'b0;
      end else if (req1) begin
        grant = 1'b1;
        win   = 1'b1;
      end
    end
  end

  always_comb begin
    gnt0      = grant && !win;
    gnt1      = grant && win;
    cpu_stall = req0 && !gnt0;
    ram_en    = grant;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant) begin
      ram_we    = win ? we1    : we0;
      ram_addr  = win ? addr1  : addr0;
      ram_wdata = win ? wdata1 : wdata0;
    end
  end

  // Ownership history used for round robin and the anti-starvation limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      burst_cnt <= 8'd0;
    end else if (grant) begin
      if (win == last) begin
        if (burst_cnt != 8'hFF) burst_cnt <= burst_cnt + 8'd1;
      end else begin
        burst_cnt <= 8'd1;
        last      <= win;
      end
    end
  end

  // RAM returns data one cycle after the read strobe; it is captured the cycle after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rd_pend <= grant && !ram_we;
      rd_id   <= win;
      rvalid0 <= rd_pend && !rd_id;
      rvalid1 <= rd_pend && rd_id;
      if (rd_pend && !rd_id) rdata0 <= ram_rdata;
      if (rd_pend && rd_id)  rdata1 <= ram_rdata;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0        <= 16'd0;
      gcnt1        <= 16'd0;
      conflict_cnt <= 16'd0;
    end else begin
      if (gnt0 && (gcnt0 != 16'hFFFF)) gcnt0 <= gcnt0 + 16'd1;
      if (gnt1 && (gcnt1 != 16'hFFFF)) gcnt1 <= gcnt1 + 16'd1;
      if (req0 && req1 && (conflict_cnt != 16'hFFFF)) conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sap_mem_arbiter.sv
// Directed self-checking bench for sap_mem_arbiter with a behavioural single-port RAM.
// Statistics outputs are checked when ARB_STATS_EN is defined.
module tb_sap_mem_arbiter;

  localparam int AW        = 8;
  localparam int DW        = 16;
  localparam int MAX_BURST = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, cpu_stall;
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
`ifdef ARB_STATS_EN
  logic [15:0]   gcnt0, gcnt1, conflict_cnt;
`endif

  logic [DW-1:0] mem [256];
  int            checks = 0;
  int            errors = 0;
  logic [0:9]    burst_pat;
  int            idx;

  always #5 clk = ~clk;

  sap_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .cpu_stall(cpu_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef ARB_STATS_EN
    .gcnt0(gcnt0), .gcnt1(gcnt1), .conflict_cnt(conflict_cnt),
`endif
    .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r,
                                input logic q0, input logic w0, input logic [AW-1:0] a0,
                                input logic [DW-1:0] d0, input logic l0,
                                input logic q1, input logic w1, input logic [AW-1:0] a1,
                                input logic [DW-1:0] d1, input logic l1);
    @(posedge clk);
    #1;
    rst = r;
    req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
    req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0; lock0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;
    ram_rdata = '0;

    // Two reset cycles with both ports requesting: nothing may be issued.
    @(negedge clk);
    check_output("rst_gnt0", gnt0, 0);
    check_output("rst_gnt1", gnt1, 0);
    check_output("rst_ram_en", ram_en, 0);
    apply_stimulus(1, 1,0,8'h00,16'h0,0, 1,0,8'h00,16'h0,0);
    check_output("rst_ram_en2", ram_en, 0);
    check_output("rst_rvalid0", rvalid0, 0);
    check_output("rst_rvalid1", rvalid1, 0);

    // Contention without lock alternates 0,1,0,1 starting with port 0.
    apply_stimulus(0, 1,1,8'h10,16'h00A0,0, 1,1,8'h20,16'h00B0,0);
    check_output("cont1_gnt0", gnt0, 1);
    check_output("cont1_gnt1", gnt1, 0);
    check_output("cont1_addr", ram_addr, 8'h10);
    check_output("cont1_stall", cpu_stall, 0);
    apply_stimulus(0, 1,1,8'h10,16'h00A0,0, 1,1,8'h20,16'h00B0,0);
    check_output("cont2_gnt1", gnt1, 1);
    check_output("cont2_addr", ram_addr, 8'h20);
    check_output("cont2_wdata", ram_wdata, 16'h00B0);
    check_output("cont2_stall", cpu_stall, 1);
    apply_stimulus(0, 1,1,8'h10,16'h00A0,0, 1,1,8'h20,16'h00B0,0);
    check_output("cont3_gnt0", gnt0, 1);
    check_output("cont3_stall", cpu_stall, 0);
    apply_stimulus(0, 1,1,8'h10,16'h00A0,0, 1,1,8'h20,16'h00B0,0);
    check_output("cont4_gnt1", gnt1, 1);
    check_output("cont4_stall", cpu_stall, 1);

    // Loader preloads RAM[5], then the CPU reads it back.
    apply_stimulus(0, 0,0,8'h00,16'h0,0, 1,1,8'h05,16'h1234,0);
    check_output("load_gnt1", gnt1, 1);
    check_output("load_we", ram_we, 1);
    apply_stimulus(0, 1,0,8'h05,16'h0,0, 0,0,8'h00,16'h0,0);
    check_output("rd_gnt0", gnt0, 1);
    check_output("rd_ram_we", ram_we, 0);
    check_output("rd_ram_addr", ram_addr, 8'h05);
    apply_stimulus(0, 0,0,8'h00,16'h0,0, 0,0,8'h00,16'h0,0);
    check_output("rd_lat1_rvalid0", rvalid0, 0);
    apply_stimulus(0, 0,0,8'h00,16'h0,0, 0,0,8'h00,16'h0,0);
    check_output("rd_rvalid0", rvalid0, 1);
    check_output("rd_rdata0", rdata0, 16'h1234);
    check_output("rd_rvalid1", rvalid1, 0);
    apply_stimulus(0, 0,0,8'h00,16'h0,0, 0,0,8'h00,16'h0,0);
    check_output("rd_rvalid0_pulse", rvalid0, 0);
    check_output("rd_rdata0_hold", rdata0, 16'h1234);

    // Locked loader burst against a CPU that keeps requesting, limit of 3.
    burst_pat = 10'b1110111011;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(0, 1,1,8'h40,16'hC0C0,0, 1,1,8'(idx),16'hB000 + 16'(idx),1);
      check_output($sformatf("burst%0d_gnt1", k), gnt1, burst_pat[k]);
      check_output($sformatf("burst%0d_gnt0", k), gnt0, !burst_pat[k]);
      if (burst_pat[k]) idx++;
    end
    apply_stimulus(0, 0,0,8'h00,16'h0,0, 0,0,8'h00,16'h0,0);
    for (int i = 0; i < 8; i++)
      check_output($sformatf("burst_mem%0d", i), mem[i], 16'hB000 + 16'(i));

    // Reset one cycle after a read grant drops the pending read.
    apply_stimulus(0, 1,0,8'h05,16'h0,0, 0,0,8'h00,16'h0,0);
    check_output("rstrd_gnt0", gnt0, 1);
    apply_stimulus(1, 1,0,8'h05,16'h0,0, 0,0,8'h00,16'h0,0);
    check_output("rstrd_gnt0_forced", gnt0, 0);
    check_output("rstrd_ram_en_forced", ram_en, 0);
    apply_stimulus(0, 0,0,8'h00,16'h0,0, 0,0,8'h00,16'h0,0);
    check_output("rstrd_rvalid0", rvalid0, 0);
    check_output("rstrd_rdata0", rdata0, 16'h0000);
    apply_stimulus(0, 0,0,8'h00,16'h0,0, 0,0,8'h00,16'h0,0);
    check_output("rstrd_rvalid0_late", rvalid0, 0);
    apply_stimulus(0, 1,1,8'h50,16'h1,0, 1,1,8'h51,16'h2,0);
    check_output("rstrd_tie_gnt0", gnt0, 1);
    check_output("rstrd_tie_gnt1", gnt1, 0);

    // Grant mix for the statistics counters: 10 to port 1, 5 to port 0 in total.
    for (int k = 0; k < 9; k++)
      apply_stimulus(0, 0,0,8'h00,16'h0,0, 1,1,8'h60,16'h3,0);
    check_output("stats_gnt1_single", gnt1, 1);
    for (int k = 0; k < 4; k++)
      apply_stimulus(0, 1,1,8'h61,16'h4,0, 0,0,8'h00,16'h0,0);
    check_output("stats_gnt0_single", gnt0, 1);
    apply_stimulus(0, 1,1,8'h62,16'h5,0, 1,1,8'h63,16'h6,0);
    check_output("stats_tie_gnt1", gnt1, 1);
    apply_stimulus(0, 0,0,8'h00,16'h0,0, 0,0,8'h00,16'h0,0);
`ifdef ARB_STATS_EN
    check_output("stats_gcnt0", gcnt0, 16'd5);
    check_output("stats_gcnt1", gcnt1, 16'd10);
    check_output("stats_conflict", conflict_cnt, 16'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
